// File: rtl/matrix_pkg.sv
// Shared definitions for the determinant datapath: matrix geometry, loader
// state encoding, and the element bit-offset helper used by all consumers.
package matrix_pkg;

    localparam int N      = 5;
    localparam int DATA_W = 8;
    localparam int MAT_W  = N * N * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } loader_state_t;

    // Bit offset of element[i][j] inside the flat row-major matrix bus.
    function automatic logic [7:0] elem_lsb(input logic [2:0] i, input logic [2:0] j);
        int lsb;
        lsb = int'(i) * N * DATA_W + int'(j) * DATA_W;
        return lsb[7:0];
    endfunction

    // Restrict a requested dimension to the supported range 2..N.
    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        logic [2:0] r;
        if (s < 3'd2) begin
            r = 3'd2;
        end else if (s > 3'(N)) begin
            r = 3'(N);
        end else begin
            r = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column walker over an active size x size block; wraps the column at
// size-1 and flags the final element of the block.
module matrix_index_counter
    import matrix_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       inc,
    input  logic [2:0] size,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       last
);

    logic [2:0] row_r;
    logic [2:0] col_r;
    logic [2:0] size_m1_s;

    assign size_m1_s = size - 3'd1;

    // Advance column on each increment, carrying into the row at the wrap point.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_r <= 3'd0;
            col_r <= 3'd0;
        end else if (clear) begin
            row_r <= 3'd0;
            col_r <= 3'd0;
        end else if (inc) begin
            if (col_r == size_m1_s) begin
                col_r <= 3'd0;
                row_r <= row_r + 3'd1;
            end else begin
                col_r <= col_r + 3'd1;
            end
        end
    end

    assign row  = row_r;
    assign col  = col_r;
    assign last = (row_r == size_m1_s) && (col_r == size_m1_s);

endmodule

// File: rtl/matrix_loader.sv
// Streams row-major bytes into the packed matrix bus and holds the result
// until consumed. Optional abort input enabled by MATRIX_LOADER_ABORT_EN.
module matrix_loader
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        size,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [MAT_W-1:0]  matrix_a,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef MATRIX_LOADER_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy
);

    loader_state_t     state_r;
    logic [MAT_W-1:0]  matrix_r;
    logic [2:0]        size_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;

    logic              abort_s;
    logic              beat_s;
    logic              clear_s;
    logic [2:0]        row_s;
    logic [2:0]        col_s;
    logic              last_s;

`ifdef MATRIX_LOADER_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // in_ready_r is high only in LOAD, so it doubles as the state qualifier.
    assign beat_s  = in_valid & in_ready_r & ~abort_s;
    assign clear_s = (state_r == IDLE) & start;

    matrix_index_counter u_index (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_s),
        .inc   (beat_s),
        .size  (size_r),
        .row   (row_s),
        .col   (col_s),
        .last  (last_s)
    );

    // Loader FSM with registered handshake outputs and matrix storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            matrix_r    <= '0;
            size_r      <= 3'd2;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= LOAD;
                        size_r     <= clamp_size(size);
                        matrix_r   <= '0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort_s) begin
                        state_r    <= IDLE;
                        matrix_r   <= '0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end else if (beat_s) begin
                        matrix_r[elem_lsb(row_s, col_s) +: DATA_W] <= in_data;
                        if (last_s) begin
                            state_r     <= HOLD;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (abort_s) begin
                        state_r     <= IDLE;
                        matrix_r    <= '0;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign matrix_a  = matrix_r;

endmodule
